// File: rtl/mesa_rx_framer.sv
// mesa_rx_framer
//   Turns an ASCII-hex character stream from a UART into framed packets.
//   Two hex characters form one byte, high nibble first. A packet is
//   F0 <slot> <cmd> <len> <len payload bytes>. Newline (0x0A) inside a
//   packet, or too long a silence between characters, aborts the packet.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   rx_byte    in   [7:0] character from the UART, qualified by rx_rdy
//   rx_rdy     in   one-clock strobe for rx_byte
//   pkt_slot   out  [7:0] slot byte of the current packet (held)
//   pkt_cmd    out  [7:0] command byte of the current packet (held)
//   pkt_len    out  [7:0] payload length of the current packet (held)
//   pkt_start  out  pulse when the header is complete
//   out_byte   out  [7:0] decoded payload byte (held)
//   out_vld    out  pulse qualifying out_byte
//   pkt_done   out  pulse with the last payload byte (or with pkt_start if len=0)
//   pkt_err    out  pulse on packet abort
//   dbg_state  out  [2:0] current framer state, for observation only
//
// Handshake: rx_byte is sampled only on clocks where rx_rdy=1; there is no
// back-pressure. Every output is a flop; pulses appear one clock after the
// rx_rdy that completes the byte and last exactly one clock.
module mesa_rx_framer #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_rdy,
  output logic [7:0] pkt_slot,
  output logic [7:0] pkt_cmd,
  output logic [7:0] pkt_len,
  output logic       pkt_start,
  output logic [7:0] out_byte,
  output logic       out_vld,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SLOT    = 3'd1,
    ST_CMD     = 3'd2,
    ST_LEN     = 3'd3,
    ST_PAYLOAD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  hi_nib_q, hi_nib_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] idle_q, idle_d;
  logic [7:0]  pkt_slot_q, pkt_slot_d;
  logic [7:0]  pkt_cmd_q, pkt_cmd_d;
  logic [7:0]  pkt_len_q, pkt_len_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        pkt_start_q, pkt_start_d;
  logic        out_vld_q, out_vld_d;
  logic        pkt_done_q, pkt_done_d;
  logic        pkt_err_q, pkt_err_d;

  // Hex character decode
  logic       is_hex;
  logic [3:0] nib;
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_byte[3:0] + 4'd9;  // 'A'/'a' low nibble is 1 -> 10
    end
  end

  logic       byte_vld;
  logic [7:0] dec_byte;
  assign dec_byte = {hi_nib_q, nib};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hi_nib_d    = hi_nib_q;
    cnt_d       = cnt_q;
    pkt_slot_d  = pkt_slot_q;
    pkt_cmd_d   = pkt_cmd_q;
    pkt_len_d   = pkt_len_q;
    out_byte_d  = out_byte_q;
    pkt_start_d = 1'b0;
    out_vld_d   = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_err_d   = 1'b0;
    byte_vld    = 1'b0;

    // Idle counter: only runs while a packet is open and the line is quiet.
    if (rx_rdy || state_q == ST_IDLE) idle_d = 16'd0;
    else if (idle_q != 16'hFFFF)      idle_d = idle_q + 16'd1;
    else                              idle_d = idle_q;

    // A character always wins over the timeout in the same clock.
    if (rx_rdy) begin
      if (rx_byte == 8'h0A) begin
        phase_d = 1'b0;
        if (state_q != ST_IDLE) begin
          pkt_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end else if (!is_hex) begin
        phase_d = 1'b0;  // drops a pending high nibble
      end else if (!phase_q) begin
        hi_nib_d = nib;
        phase_d  = 1'b1;
      end else begin
        phase_d  = 1'b0;
        byte_vld = 1'b1;
      end
    end else if (state_q != ST_IDLE && idle_q == TIMEOUT) begin
      pkt_err_d = 1'b1;
      phase_d   = 1'b0;
      state_d   = ST_IDLE;
    end

    if (byte_vld) begin
      case (state_q)
        ST_IDLE: if (dec_byte == 8'hF0) state_d = ST_SLOT;
        ST_SLOT: begin
          pkt_slot_d = dec_byte;
          state_d    = ST_CMD;
        end
        ST_CMD: begin
          pkt_cmd_d = dec_byte;
          state_d   = ST_LEN;
        end
        ST_LEN: begin
          pkt_len_d   = dec_byte;
          cnt_d       = dec_byte;
          pkt_start_d = 1'b1;
          if (dec_byte == 8'd0) begin
            pkt_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          out_byte_d = dec_byte;
          out_vld_d  = 1'b1;
          cnt_d      = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            pkt_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      hi_nib_q    <= 4'd0;
      cnt_q       <= 8'd0;
      idle_q      <= 16'd0;
      pkt_slot_q  <= 8'd0;
      pkt_cmd_q   <= 8'd0;
      pkt_len_q   <= 8'd0;
      out_byte_q  <= 8'd0;
      pkt_start_q <= 1'b0;
      out_vld_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hi_nib_q    <= hi_nib_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      pkt_slot_q  <= pkt_slot_d;
      pkt_cmd_q   <= pkt_cmd_d;
      pkt_len_q   <= pkt_len_d;
      out_byte_q  <= out_byte_d;
      pkt_start_q <= pkt_start_d;
      out_vld_q   <= out_vld_d;
      pkt_done_q  <= pkt_done_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  assign pkt_slot  = pkt_slot_q;
  assign pkt_cmd   = pkt_cmd_q;
  assign pkt_len   = pkt_len_q;
  assign out_byte  = out_byte_q;
  assign pkt_start = pkt_start_q;
  assign out_vld   = out_vld_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_err   = pkt_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mesa_rx_framer.sv
module tb_mesa_rx_framer;

  localparam logic [15:0] TMO = 16'd100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_rdy = 1'b0;
  logic [7:0] pkt_slot, pkt_cmd, pkt_len, out_byte;
  logic       pkt_start, out_vld, pkt_done, pkt_err;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  mesa_rx_framer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_rdy(rx_rdy),
    .pkt_slot(pkt_slot), .pkt_cmd(pkt_cmd), .pkt_len(pkt_len),
    .pkt_start(pkt_start), .out_byte(out_byte), .out_vld(out_vld),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Event word: [31:28] = {err, done, start, vld}; [23:0] = {slot,cmd,len}
  // on start, else {16'h0, byte} on vld, else 0. One word per active clock.
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  // ---------------- monitor ----------------
  int cyc = 0;
  int last_rdy_cyc = 0;
  int err_cyc = -1;
  always @(negedge clk) begin
    cyc++;
    if (rx_rdy) last_rdy_cyc = cyc;
    if (!reset && (pkt_err || pkt_done || pkt_start || out_vld)) begin
      if (pkt_err) err_cyc = cyc;
      if (pkt_start)
        obs_q.push_back({pkt_err, pkt_done, pkt_start, out_vld, 4'h0, pkt_slot, pkt_cmd, pkt_len});
      else if (out_vld)
        obs_q.push_back({pkt_err, pkt_done, pkt_start, out_vld, 4'h0, 16'h0, out_byte});
      else
        obs_q.push_back({pkt_err, pkt_done, pkt_start, out_vld, 28'h0});
    end
  end

  // ---------------- reference model ----------------
  // Bytes of the packet collected so far; empty means no packet open.
  logic [7:0] m_pkt[$];
  bit         m_pend = 0;
  logic [3:0] m_hi = 4'd0;

  function automatic bit is_hex_c(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return 4'(c - "0");
    if (c >= "A" && c <= "F") return 4'(c - "A" + 10);
    return 4'(c - "a" + 10);
  endfunction

  function automatic void m_abort();
    if (m_pkt.size() > 0) exp_q.push_back({4'b1000, 28'h0});
    m_pkt.delete();
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    int n;
    if (m_pkt.size() == 0) begin
      if (b == 8'hF0) m_pkt.push_back(b);
      return;
    end
    m_pkt.push_back(b);
    n = m_pkt.size();
    if (n == 4) begin
      if (b == 8'd0) begin
        exp_q.push_back({4'b0110, 4'h0, m_pkt[1], m_pkt[2], m_pkt[3]});
        m_pkt.delete();
      end else begin
        exp_q.push_back({4'b0010, 4'h0, m_pkt[1], m_pkt[2], m_pkt[3]});
      end
    end else if (n > 4) begin
      if (n == 4 + int'(m_pkt[3])) begin
        exp_q.push_back({4'b0101, 4'h0, 16'h0, b});
        m_pkt.delete();
      end else begin
        exp_q.push_back({4'b0001, 4'h0, 16'h0, b});
      end
    end
  endfunction

  function automatic void m_char(input logic [7:0] c);
    if (c == 8'h0A) begin
      m_pend = 0;
      m_abort();
    end else if (!is_hex_c(c)) begin
      m_pend = 0;
    end else if (!m_pend) begin
      m_hi = hex_val(c);
      m_pend = 1;
    end else begin
      m_pend = 0;
      m_byte({m_hi, hex_val(c)});
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_char(input logic [7:0] c);
    @(posedge clk); #1;
    rx_byte = c;
    rx_rdy  = 1'b1;
    m_char(c);
    @(posedge clk); #1;
    rx_rdy  = 1'b0;
    rx_byte = 8'($urandom);  // junk while not qualified
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  function automatic logic [7:0] nib_char(input logic [3:0] n);
    if (n < 10) return 8'("0" + n);
    if ($urandom_range(0, 1) == 1) return 8'("a" + n - 10);
    return 8'("A" + n - 10);
  endfunction

  task automatic send_hex(input logic [7:0] b);
    send_char(nib_char(b[7:4]));
    send_char(nib_char(b[3:0]));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_events(input string tag);
    int n;
    idle(4);
    n_checks++;
    assert (obs_q.size() === exp_q.size())
      else begin n_errors++; $error("FAIL %s count: observed %0d expected %0d", tag, obs_q.size(), exp_q.size()); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      assert (obs_q[i] === exp_q[i])
        else begin n_errors++; $error("FAIL %s event%0d: observed %h expected %h", tag, i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin n_errors++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    rx_rdy = 1'b0;
    m_pkt.delete();
    m_pend = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_val("reset_outputs",
              {pkt_slot, pkt_cmd, pkt_len, out_byte, 4'h0, pkt_start, out_vld, pkt_done, pkt_err},
              36'h0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] len, nb;
    bit abort;

    apply_reset(3);
    check_val("reset_state", {29'h0, dbg_state}, 32'h0);

    // Basic packet
    send_str("F003A5021234\n");
    check_events("basic");
    check_val("hold_slot", {24'h0, pkt_slot}, 32'h03);
    check_val("hold_cmd", {24'h0, pkt_cmd}, 32'hA5);
    check_val("hold_len", {24'h0, pkt_len}, 32'h02);
    check_val("hold_byte", {24'h0, out_byte}, 32'h34);

    // Mixed case, space, zero length
    send_str("f0 0aBb00\n");
    check_events("zero_len");

    // Early newline
    send_str("F00102 03AA\n");
    check_events("early_nl");

    // Timeout: error lands exactly TIMEOUT clocks after the idle count starts
    err_cyc = -1;
    send_str("F001");
    idle(int'(TMO) + 8);
    m_pend = 0;
    m_abort();
    check_val("timeout_latency", err_cyc - last_rdy_cyc, int'(TMO) + 2);
    send_str("F0112203C0FFEE");
    check_events("timeout");

    // Garbage, odd nibble, then a packet
    send_str("ZZ7F");
    send_str("5");
    send_str("G");
    send_str("F0030401AB");
    check_events("garbage");

    // F0 inside a packet is plain data
    send_str("F0F0F002F0F0");
    check_events("f0_as_data");

    // Reset mid-payload, then a packet right after release
    send_str("F001020411");
    apply_reset(2);
    check_events("pre_reset");
    send_str("F0050601EE");
    check_events("post_reset");

    // Randomised packets, some truncated by newline, some with idle junk
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        nb = 8'($urandom);
        send_hex(nb);
        if ($urandom_range(0, 1) == 1) send_char(" ");
      end
      len   = 8'($urandom_range(0, 5));
      abort = ($urandom_range(0, 4) == 0) && (len != 0);
      send_hex(8'hF0);
      send_hex(8'($urandom));
      if ($urandom_range(0, 1) == 1) send_char(" ");
      send_hex(8'($urandom));
      send_hex(len);
      nb = abort ? 8'($urandom_range(0, int'(len) - 1)) : len;
      for (int j = 0; j < int'(nb); j++) send_hex(8'($urandom));
      if (abort || $urandom_range(0, 1) == 1) send_char(8'h0A);
      check_events($sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mesa_rx_framer.md
MESA_RX_FRAMER -- requirements
Module: mesa_rx_framer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000, meaning the number of idle clocks allowed between rx_rdy pulses inside a packet before it is aborted.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port rx_byte, input, 8, received ASCII character from the upstream UART; valid only when rx_rdy=1.
REQ-005 SHALL have port rx_rdy, input, 1, one-clock strobe qualifying rx_byte.
REQ-006 SHALL have port pkt_slot, output, 8, slot byte of the current packet.
REQ-007 SHALL have port pkt_cmd, output, 8, command byte of the current packet.
REQ-008 SHALL have port pkt_len, output, 8, payload length of the current packet.
REQ-009 SHALL have port pkt_start, output, 1, one-clock pulse when the header is complete.
REQ-010 SHALL have port out_byte, output, 8, decoded payload byte.
REQ-011 SHALL have port out_vld, output, 1, one-clock strobe qualifying out_byte.
REQ-012 SHALL have port pkt_done, output, 1, one-clock pulse after the last payload byte.
REQ-013 SHALL have port pkt_err, output, 1, one-clock pulse on packet abort.

Function
REQ-014 SHALL decode characters 0x30-0x39, 0x41-0x46 and 0x61-0x66 to nibble values 0-15; all other characters are non-hex.
REQ-015 SHALL pair hex nibbles into a byte, high nibble first; a nibble-phase flag tracks odd/even.
REQ-016 SHALL, on a non-hex character other than 0x0A, clear the nibble phase and discard any pending high nibble, with no state change.
REQ-017 SHALL treat 0x0A as end-of-line:
- clears the nibble phase;
- in any state other than IDLE, aborts the packet and pulses pkt_err.
REQ-018 SHALL implement the FSM: IDLE -> SLOT -> CMD -> LEN -> PAYLOAD -> IDLE; each transition is taken on a completed decoded byte.
REQ-019 SHALL, in IDLE:
- on byte 0xF0, go to SLOT;
- discard any other byte silently, with no error.
REQ-020 SHALL capture the SLOT byte into pkt_slot and the CMD byte into pkt_cmd.
REQ-021 SHALL capture the LEN byte into pkt_len, pulse pkt_start, and go to PAYLOAD; a payload down-counter loads with LEN.
REQ-022 SHALL handle LEN=0 by pulsing pkt_start and pkt_done together in the same clock and returning to IDLE.
REQ-023 SHALL, in PAYLOAD, present each decoded byte on out_byte with out_vld=1 and decrement the counter.
REQ-024 SHALL, on the last payload byte, pulse out_vld and pkt_done in the same clock and return to IDLE.
REQ-025 SHALL ignore characters after pkt_done and before the next 0xF0, except as IDLE input.
REQ-026 SHALL register all outputs; out_vld, pkt_start, pkt_done and pkt_err assert in the clock after the rx_rdy carrying the low-nibble character; latency is 1 clock.
REQ-027 SHALL hold out_byte, pkt_slot, pkt_cmd and pkt_len stable until overwritten; pulses are exactly one clock wide.
REQ-028 SHALL run a 16-bit idle counter that clears on every rx_rdy and in IDLE, and otherwise increments with saturation.
REQ-029 SHALL, when the idle counter equals TIMEOUT in a non-IDLE state, pulse pkt_err, clear the nibble phase and go to IDLE.
REQ-030 SHALL give rx_rdy priority over timeout when both occur in the same clock: the character is processed and no error is raised.
REQ-031 SHALL NOT accept 0xF0 outside IDLE as a resync; it is consumed as ordinary header or payload data.
REQ-032 SHALL ignore rx_byte whenever rx_rdy=0.

Reset
REQ-033 SHALL, on reset=1, synchronously force:
- FSM to IDLE;
- nibble phase, payload counter and idle counter to 0;
- all outputs to 0.
REQ-034 SHALL, on reset asserted mid-packet, discard the partial packet with no pkt_err or pkt_done, and accept a new packet starting on the first rx_rdy after release.

Verification
REQ-035 Basic packet: send "F0" "03" "A5" "02" "1234" "\n" -> pkt_start with slot=0x03, cmd=0xA5, len=0x02; out_vld 0x12, then 0x34 together with pkt_done; no pkt_err.
REQ-036 Mixed case and zero length: send "f0 0aBb00\n" -> space clears the nibble phase harmlessly; pkt_start and pkt_done in the same clock with slot=0x0A, cmd=0xBB, len=0; no out_vld.
REQ-037 Early newline: send "F00102 03AA\n" -> pkt_start len=3; one out_vld 0xAA; pkt_err on the "\n"; no pkt_done.
REQ-038 Timeout: with TIMEOUT=100, send "F001" then idle 100 clocks -> pkt_err pulse; a following full packet decodes normally.
REQ-039 Garbage and odd nibble: send "ZZ7F" then "5" then "G" then "F0..." -> 0x7F is discarded in IDLE; the lone "5" is dropped by "G"; the packet after F0 decodes correctly.
REQ-040 Reset mid-payload: assert reset after 1 of 4 payload bytes -> all outputs 0 with no pulses; the next full packet decodes correctly.
